// File: rtl/stopwatch_display.sv
// stopwatch_display
//   Multiplexed 4-digit common-anode 7-segment driver for a stopwatch, shown
//   as "_M.SS". The time inputs are snapshotted once per scan frame so a
//   frame never mixes old and new digits. The field being adjusted blinks,
//   and out-of-range values are shown as dashes.
//
// Parameters
//   REFRESH_DIV   clk cycles per digit slot (>= 2)
//   BLINK_FRAMES  scan frames per blink half-period (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seconds      seconds from the stopwatch counter (0-59 valid)
//   minutes      minutes from the stopwatch counter (0-9 valid)
//   adjust_en    adjust mode; enables blinking of the selected field
//   adjust_sel   field to blink: 0 = seconds, 1 = minutes
//   an           digit anodes, active low, an[0] = rightmost digit
//   seg          segments {g,f,e,d,c,b,a}, active low
//   dp           decimal point, active low
module stopwatch_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] seconds,
  input  logic [3:0] minutes,
  input  logic       adjust_en,
  input  logic       adjust_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCW = $clog2(REFRESH_DIV);
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(REFRESH_DIV - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]     digit_idx_q, digit_idx_d;
  logic [5:0]     snap_sec_q, snap_sec_d;
  logic [3:0]     snap_min_q, snap_min_d;
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_phase_q, blink_phase_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;

  logic       slot_wrap;
  logic       frame_wrap;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic       sec_ok;
  logic       min_ok;
  logic       blank_sec;
  logic       blank_min;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    logic [6:0] c;
    case (v)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = SEG_DASH;
    endcase
    return c;
  endfunction

  assign slot_wrap  = (scan_cnt_q == SCAN_LAST);
  assign frame_wrap = slot_wrap && (digit_idx_q == 2'd3);

  // Scan timing, per-frame snapshot and blink timebase.
  always_comb begin
    scan_cnt_d    = slot_wrap ? '0 : scan_cnt_q + SCW'(1);
    digit_idx_d   = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    snap_sec_d    = snap_sec_q;
    snap_min_d    = snap_min_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_wrap) begin
      snap_sec_d = seconds;
      snap_min_d = minutes;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end
  end

  // Display decode; works on the registered slot and snapshot so outputs
  // trail digit_idx by exactly one cycle.
  assign sec_ones  = 4'(snap_sec_q % 6'd10);
  assign sec_tens  = 4'(snap_sec_q / 6'd10);
  assign sec_ok    = (snap_sec_q <= 6'd59);
  assign min_ok    = (snap_min_q <= 4'd9);
  assign blank_sec = adjust_en && blink_phase_q && !adjust_sel;
  assign blank_min = adjust_en && blink_phase_q && adjust_sel;

  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    case (digit_idx_q)
      2'd0: begin
        if (!blank_sec) begin
          an_d  = 4'b1110;
          seg_d = sec_ok ? seg_code(sec_ones) : SEG_DASH;
        end
      end
      2'd1: begin
        if (!blank_sec) begin
          an_d  = 4'b1101;
          seg_d = sec_ok ? seg_code(sec_tens) : SEG_DASH;
        end
      end
      2'd2: begin
        if (!blank_min) begin
          an_d  = 4'b1011;
          seg_d = min_ok ? seg_code(snap_min_q) : SEG_DASH;
          dp_d  = 1'b0;
        end
      end
      default: begin
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      digit_idx_q   <= 2'd0;
      snap_sec_q    <= 6'd0;
      snap_min_q    <= 4'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= 4'b1111;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      snap_sec_q    <= snap_sec_d;
      snap_min_q    <= snap_min_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

  localparam int R  = 4;
  localparam int BF = 2;
  localparam int FR = 4 * R;
  localparam int HN = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] seconds = '0;
  logic [3:0] minutes = '0;
  logic       adjust_en = 1'b0;
  logic       adjust_sel = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int n          = 0;

  logic [5:0] hs   [0:HN-1];
  logic [3:0] hm   [0:HN-1];
  logic       he   [0:HN-1];
  logic       hsel [0:HN-1];

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  stopwatch_display #(.REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seconds    (seconds),
    .minutes    (minutes),
    .adjust_en  (adjust_en),
    .adjust_sel (adjust_sel),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  // Apply inputs, remember what the DUT sees at edge n+1, advance one edge.
  task automatic tick(input logic [5:0] s, input logic [3:0] m, input logic e, input logic sl);
    seconds    = s;
    minutes    = m;
    adjust_en  = e;
    adjust_sel = sl;
    if (n + 1 < HN) begin
      hs[n+1]   = s;
      hm[n+1]   = m;
      he[n+1]   = e;
      hsel[n+1] = sl;
    end
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
  endtask

  // Expected {an,seg,dp} after k edges since reset release. Time is reduced
  // to (frame, slot); the snapshot is what the inputs held at the edge that
  // began the frame, and the blink phase follows from the frame number.
  function automatic logic [11:0] model(input int k);
    int m, slot, frame, s, mi;
    bit phase, blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (k <= 0) return {4'b1111, 7'b1111111, 1'b1};
    m     = k - 1;
    slot  = (m / R) % 4;
    frame = m / FR;
    if (frame == 0) begin
      s  = 0;
      mi = 0;
    end else begin
      s  = int'(hs[frame*FR]);
      mi = int'(hm[frame*FR]);
    end
    phase = ((frame / BF) % 2) == 1;
    blank = he[k] && phase && (hsel[k] ? (slot == 2) : (slot < 2));
    e_an  = 4'b1111;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    if (!blank) begin
      if (slot == 0) begin
        e_an  = 4'b1110;
        e_seg = (s > 59) ? 7'b0111111 : seg_tab[s % 10];
      end else if (slot == 1) begin
        e_an  = 4'b1101;
        e_seg = (s > 59) ? 7'b0111111 : seg_tab[s / 10];
      end else if (slot == 2) begin
        e_an  = 4'b1011;
        e_seg = (mi > 9) ? 7'b0111111 : seg_tab[mi];
        e_dp  = 1'b0;
      end
    end
    return {e_an, e_seg, e_dp};
  endfunction

  task automatic test_reset();
    logic [11:0] exp;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      assert_cnt++;
      if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
        fail_cnt++;
        $display("FAIL reset_hold: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", an, seg, dp);
      end
    end
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick(6'd0, 4'd0, 1'b0, 1'b0);
      exp = model(n);
      assert_cnt++;
      if ({an, seg, dp} !== exp) begin
        fail_cnt++;
        $display("FAIL reset_first_slot n=%0d: got %b_%b_%b want %b", n, an, seg, dp, exp);
      end
      if (n == 4) begin
        assert_cnt++;
        if (an !== 4'b1110) begin
          fail_cnt++;
          $display("FAIL reset_cycle4_an: got %b want 1110", an);
        end
      end
      if (n == 5) begin
        assert_cnt++;
        if (an !== 4'b1101) begin
          fail_cnt++;
          $display("FAIL reset_cycle5_an: got %b want 1101", an);
        end
      end
    end
  endtask

  task automatic test_decode();
    logic [11:0] exp;
    do_reset();
    for (int i = 0; i < 2 * FR; i++) begin
      tick(6'd37, 4'd5, 1'b0, 1'b0);
      exp = model(n);
      assert_cnt++;
      if ({an, seg, dp} !== exp) begin
        fail_cnt++;
        $display("FAIL decode n=%0d: got %b_%b_%b want %b", n, an, seg, dp, exp);
      end
      if (n == FR + 2) begin
        assert_cnt++;
        if ({an, seg, dp} !== {4'b1110, 7'b1111000, 1'b1}) begin
          fail_cnt++;
          $display("FAIL decode_idx0: got %b_%b_%b want 1110_1111000_1", an, seg, dp);
        end
      end
      if (n == FR + R + 2) begin
        assert_cnt++;
        if ({an, seg, dp} !== {4'b1101, 7'b0110000, 1'b1}) begin
          fail_cnt++;
          $display("FAIL decode_idx1: got %b_%b_%b want 1101_0110000_1", an, seg, dp);
        end
      end
      if (n == FR + 2 * R + 2) begin
        assert_cnt++;
        if ({an, seg, dp} !== {4'b1011, 7'b0010010, 1'b0}) begin
          fail_cnt++;
          $display("FAIL decode_idx2: got %b_%b_%b want 1011_0010010_0", an, seg, dp);
        end
      end
      if (n == FR + 3 * R + 2) begin
        assert_cnt++;
        if ({an, dp} !== {4'b1111, 1'b1}) begin
          fail_cnt++;
          $display("FAIL decode_idx3: got an=%b dp=%b want an=1111 dp=1", an, dp);
        end
      end
    end
  endtask

  // Continues from test_decode: frame 2 starts with 37, seconds become 42
  // while idx1 of frame 2 is on display.
  task automatic test_snapshot();
    logic [11:0] exp;
    logic [5:0]  s;
    for (int i = 0; i < 2 * FR; i++) begin
      s = (n + 1 >= 2 * FR + R + 2) ? 6'd42 : 6'd37;
      tick(s, 4'd5, 1'b0, 1'b0);
      exp = model(n);
      assert_cnt++;
      if ({an, seg, dp} !== exp) begin
        fail_cnt++;
        $display("FAIL snapshot n=%0d: got %b_%b_%b want %b", n, an, seg, dp, exp);
      end
      if (n == 2 * FR + R + 2) begin
        assert_cnt++;
        if (seg !== 7'b0110000) begin
          fail_cnt++;
          $display("FAIL snapshot_midframe_idx1: got %b want 0110000", seg);
        end
      end
      if (n == 3 * FR + 2) begin
        assert_cnt++;
        if (seg !== 7'b0100100) begin
          fail_cnt++;
          $display("FAIL snapshot_next_idx0: got %b want 0100100", seg);
        end
      end
      if (n == 3 * FR + R + 2) begin
        assert_cnt++;
        if (seg !== 7'b0011001) begin
          fail_cnt++;
          $display("FAIL snapshot_next_idx1: got %b want 0011001", seg);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [11:0] exp;
    int base;
    base = n;
    for (int i = 0; i < 3 * FR; i++) begin
      tick(6'd60, 4'd12, 1'b0, 1'b0);
      exp = model(n);
      assert_cnt++;
      if ({an, seg, dp} !== exp) begin
        fail_cnt++;
        $display("FAIL range n=%0d: got %b_%b_%b want %b", n, an, seg, dp, exp);
      end
      if (n == base + 2 * FR + 2 || n == base + 2 * FR + R + 2) begin
        assert_cnt++;
        if (seg !== 7'b0111111) begin
          fail_cnt++;
          $display("FAIL range_sec_dash n=%0d: got %b want 0111111", n, seg);
        end
      end
      if (n == base + 2 * FR + 2 * R + 2) begin
        assert_cnt++;
        if ({seg, dp} !== {7'b0111111, 1'b0}) begin
          fail_cnt++;
          $display("FAIL range_min_dash: got seg=%b dp=%b want 0111111 0", seg, dp);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [11:0] exp;
    logic sl;
    do_reset();
    for (int i = 0; i < 12 * FR; i++) begin
      sl = (i < 8 * FR) ? 1'b1 : 1'b0;
      tick(6'd37, 4'd5, 1'b1, sl);
      exp = model(n);
      assert_cnt++;
      if ({an, seg, dp} !== exp) begin
        fail_cnt++;
        $display("FAIL blink n=%0d: got %b_%b_%b want %b", n, an, seg, dp, exp);
      end
      if (n == 2 * FR + 2 * R + 2) begin
        assert_cnt++;
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
          fail_cnt++;
          $display("FAIL blink_min_off: got %b_%b_%b want 1111_1111111_1", an, seg, dp);
        end
      end
      if (n == 4 * FR + 2 * R + 2) begin
        assert_cnt++;
        if ({an, dp} !== {4'b1011, 1'b0}) begin
          fail_cnt++;
          $display("FAIL blink_min_on: got an=%b dp=%b want 1011 0", an, dp);
        end
      end
      if (n == 10 * FR + 2) begin
        assert_cnt++;
        if (an !== 4'b1111) begin
          fail_cnt++;
          $display("FAIL blink_sec_off: got an=%b want 1111", an);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    logic [5:0] s;
    logic [3:0] m;
    logic e, sl;
    s = 6'd0; m = 4'd0; e = 1'b0; sl = 1'b0;
    for (int i = 0; i < 30 * FR; i++) begin
      if ($urandom_range(0, 3) == 0) s = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) e = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) sl = 1'($urandom_range(0, 1));
      tick(s, m, e, sl);
      exp = model(n);
      assert_cnt++;
      if ({an, seg, dp} !== exp) begin
        fail_cnt++;
        $display("FAIL random n=%0d: got %b_%b_%b want %b", n, an, seg, dp, exp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] exp;
    do_reset();
    for (int i = 0; i < FR + 2 * R + 1; i++) tick(6'd37, 4'd5, 1'b0, 1'b0);
    assert_cnt++;
    if (an !== 4'b1011) begin
      fail_cnt++;
      $display("FAIL midreset_pre_an: got %b want 1011", an);
    end
    #3;
    rst_n = 1'b0;
    #1;
    assert_cnt++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      fail_cnt++;
      $display("FAIL midreset_async: got %b_%b_%b want 1111_1111111_1", an, seg, dp);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick(6'd37, 4'd5, 1'b0, 1'b0);
      exp = model(n);
      assert_cnt++;
      if ({an, seg, dp} !== exp) begin
        fail_cnt++;
        $display("FAIL midreset_after n=%0d: got %b_%b_%b want %b", n, an, seg, dp, exp);
      end
      if (n == 2 || n == R + 2 || n == 2 * R + 2) begin
        assert_cnt++;
        if (seg !== 7'b1000000) begin
          fail_cnt++;
          $display("FAIL midreset_zero n=%0d: got %b want 1000000", n, seg);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < HN; i++) begin
      hs[i] = '0; hm[i] = '0; he[i] = 1'b0; hsel[i] = 1'b0;
    end
    test_reset();
    test_decode();
    test_snapshot();
    test_out_of_range();
    test_blink();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
